// File: rtl/adc0804_sampler_if.sv
// ADC0804 parallel bus: chip select, write/read strobes, end-of-conversion and data byte.
// The master side is the conversion controller; the slave side is the converter.
interface adc0804_sampler_if;
  logic       adc_cs_n;
  logic       adc_wr_n;
  logic       adc_rd_n;
  logic       adc_intr_n;
  logic [7:0] adc_data;

  modport master (
    output adc_cs_n,
    output adc_wr_n,
    output adc_rd_n,
    input  adc_intr_n,
    input  adc_data
  );

  modport slave (
    input  adc_cs_n,
    input  adc_wr_n,
    input  adc_rd_n,
    output adc_intr_n,
    output adc_data
  );
endinterface

// File: rtl/adc0804_sampler.sv
// Paced ADC0804 conversion controller: start (CS/WR), wait for INTR, read (CS/RD), strobe result.
// Define ADC_AVG4_EN to output a 4-tap boxcar average, one clock later than the raw result.
module adc0804_sampler #(
  parameter int SAMPLE_DIV     = 25000,
  parameter int WR_CYCLES      = 3,
  parameter int RD_CYCLES      = 5,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              enable,
  adc0804_sampler_if.master adc,
  output logic [7:0]        sample,
  output logic              sample_valid,
  output logic              busy,
  output logic              timeout_err,
  output logic              overrun
);
  localparam int DIV_W   = (SAMPLE_DIV > 1) ? $clog2(SAMPLE_DIV) : 1;
  localparam int MAX_WR  = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
  localparam int CNT_MAX = (TIMEOUT_CYCLES > MAX_WR) ? TIMEOUT_CYCLES : MAX_WR;
  localparam int CNT_W   = $clog2(CNT_MAX) + 1;

  typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_READ} state_t;

  state_t           state, state_nx;
  logic [DIV_W-1:0] div_cnt;
  logic [CNT_W-1:0] cnt, cnt_nx;
  logic             tick;
  logic             intr_meta, intr_sync;
  logic             capture, to_fire;

  assign tick = enable && (div_cnt == DIV_W'(SAMPLE_DIV - 1));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)           div_cnt <= '0;
    else if (!enable || tick) div_cnt <= '0;
    else                    div_cnt <= div_cnt + 1'b1;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      intr_meta <= 1'b1;
      intr_sync <= 1'b1;
    end else begin
      intr_meta <= adc.adc_intr_n;
      intr_sync <= intr_meta;
    end
  end

  // One shared counter times the WR pulse, the INTR timeout and the RD access.
  always_comb begin
    state_nx = state;
    cnt_nx   = cnt + 1'b1;
    capture  = 1'b0;
    to_fire  = 1'b0;
    case (state)
      S_IDLE: begin
        cnt_nx = '0;
        if (tick) state_nx = S_START;
      end
      S_START: begin
        if (cnt == CNT_W'(WR_CYCLES - 1)) begin
          state_nx = S_WAIT;
          cnt_nx   = '0;
        end
      end
      S_WAIT: begin
        if (!intr_sync) begin
          state_nx = S_READ;
          cnt_nx   = '0;
        end else if (cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          to_fire  = 1'b1;
        end
      end
      S_READ: begin
        if (cnt == CNT_W'(RD_CYCLES - 1)) begin
          state_nx = S_IDLE;
          cnt_nx   = '0;
          capture  = 1'b1;
        end
      end
      default: begin
        state_nx = S_IDLE;
        cnt_nx   = '0;
      end
    endcase
  end

  // Strobes are registered from the next state so the ADC pins never glitch.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= S_IDLE;
      cnt          <= '0;
      adc.adc_cs_n <= 1'b1;
      adc.adc_wr_n <= 1'b1;
      adc.adc_rd_n <= 1'b1;
      busy         <= 1'b0;
      timeout_err  <= 1'b0;
      overrun      <= 1'b0;
    end else begin
      state        <= state_nx;
      cnt          <= cnt_nx;
      adc.adc_cs_n <= !((state_nx == S_START) || (state_nx == S_READ));
      adc.adc_wr_n <= (state_nx != S_START);
      adc.adc_rd_n <= (state_nx != S_READ);
      busy         <= (state_nx != S_IDLE);
      if (to_fire)                     timeout_err <= 1'b1;
      if (tick && (state != S_IDLE))   overrun     <= 1'b1;
    end
  end

`ifdef ADC_AVG4_EN
  function automatic logic [7:0] avg4(input logic [7:0] a, input logic [7:0] b,
                                      input logic [7:0] c, input logic [7:0] d);
    logic [9:0] sum;
    sum = 10'(a) + 10'(b) + 10'(c) + 10'(d);
    return 8'(sum >> 2);
  endfunction

  logic [7:0] hist0_p0, hist1_p0, hist2_p0, hist3_p0;
  logic       vld_p0;

  // Stage p0: shift the raw capture into the history.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hist0_p0 <= 8'h00;
      hist1_p0 <= 8'h00;
      hist2_p0 <= 8'h00;
      hist3_p0 <= 8'h00;
      vld_p0   <= 1'b0;
    end else begin
      vld_p0 <= capture;
      if (capture) begin
        hist0_p0 <= adc.adc_data;
        hist1_p0 <= hist0_p0;
        hist2_p0 <= hist1_p0;
        hist3_p0 <= hist2_p0;
      end
    end
  end

  // Stage p1: truncated average of the four most recent captures.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= 8'h00;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= vld_p0;
      if (vld_p0) sample <= avg4(hist0_p0, hist1_p0, hist2_p0, hist3_p0);
    end
  end
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sample       <= 8'h00;
      sample_valid <= 1'b0;
    end else begin
      sample_valid <= capture;
      if (capture) sample <= adc.adc_data;
    end
  end
`endif
endmodule
